divider_nbit: RTL and testbench
===============================

Name: divider_nbit

Overview:
- Parametrised sequential restoring divider; successor to the fixed 8-bit divider.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Start/done handshake with idle and not_valid status flags; sits beside datapath blocks as a shared arithmetic unit.
- Adds over the 8-bit generation: width parameter, one-cycle done strobe, ignored start while busy, defined divide-by-zero result, optional signed mode.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; rising edge active
- rst_n  in  1  asynchronous reset, active-low
- strt  in  1  start request; sampled only while idle=1
- dividend  in  WIDTH  dividend operand, captured on accepted start
- divisor  in  WIDTH  divisor operand, captured on accepted start
- quotient  out  WIDTH  registered quotient; holds until next result
- remainder  out  WIDTH  registered remainder; holds until next result
- not_valid  out  1  last result invalid (divide by zero, or signed overflow)
- idle  out  1  high when a new start will be accepted
- done  out  1  one-cycle strobe when quotient/remainder update
- signed_mode  in  1  only present with DIV_SIGNED_EN; see Optional Feature

Behaviour:
- Reset (rst_n low, async): state=IDLE; quotient=0, remainder=0, not_valid=0, done=0, idle=1; internal counter/registers cleared. Reset mid-operation aborts the division; no done is produced.
- FSM states: IDLE, CALC, FIN.
- IDLE: idle=1. strt=1 at edge k: capture operands, clear not_valid, set idle=0.
  - Divisor nonzero: go to CALC with counter=WIDTH.
  - Divisor zero: go to FIN with result preset: quotient = all ones, remainder = dividend, not_valid=1.
- CALC: each edge shifts the partial remainder left by one and brings in the next dividend MSB.
  - Trial subtract of the divisor at WIDTH+1 bits.
  - If non-negative: keep the difference and shift in quotient bit 1; else shift in 0.
  - Counter decrements; at counter=1, go to FIN.
- FIN: one edge; write the quotient/remainder outputs, pulse done=1 for exactly one cycle, set idle=1, return to IDLE.
- Latency, nonzero divisor: start sampled at edge k; done high in the cycle after edge k+WIDTH+1. For WIDTH=8, that is 9 edges after start.
- Latency, zero divisor: done high in the cycle after edge k+2.
- strt while idle=0 is ignored; no queuing. Operand changes after capture have no effect.
- strt held high continuously: a new division starts on the edge where done is asserted (idle=1 that cycle). Back-to-back throughput is WIDTH+2 cycles.
- Dividend < divisor: quotient=0, remainder=dividend. Dividend=0: quotient=0, remainder=0, not_valid=0.
- Outputs change only in FIN; otherwise they hold their previous values.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Adds the signed_mode input, sampled with the operands.
  - When signed_mode=1, operands are two's complement and converted to magnitudes at load. The quotient is negated if the operand signs differ; the remainder takes the dividend's sign. Rounding is truncation toward zero.
  - Most-negative / -1: quotient = most-negative value, remainder=0, not_valid=1.
  - Divide by zero in signed mode: same result as unsigned.
  - No added latency.
- Undefined: the port is absent and the block divides unsigned only; the overflow rule does not exist.

Test Plan:
- WIDTH=8, reset, then dividend=25, divisor=5, strt one cycle -> quotient=5, remainder=0, not_valid=0; done one cycle, 9 edges after the strt edge; idle low throughout.
- dividend=200, divisor=7 -> quotient=28, remainder=4. Pulse strt=1 at mid-CALC with dividend=9, divisor=3 -> ignored; result stays 28/4.
- dividend=37, divisor=0 -> quotient=255, remainder=37, not_valid=1, done 2 edges after start. Next start with 10/3 -> not_valid=0, quotient=3, remainder=1.
- Start 100/9, assert rst_n low at iteration 4 -> outputs 0, idle=1, no done. After release, 100/9 -> quotient=11, remainder=1.
- strt held high for 3 operations of 255/16 -> each yields quotient=15, remainder=15; done every 10 cycles; results identical.
- DIV_SIGNED_EN, signed_mode=1:
  - -25/4 -> quotient=0xFA (-6), remainder=0xFF (-1).
  - -128/-1 -> quotient=0x80, remainder=0, not_valid=1.
  - WIDTH=16 run of 60000/7 (unsigned) -> quotient=8571, remainder=3.

Source files
------------

// File: rtl/divider_nbit.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN to add the signed_mode input (two's-complement operands).
module divider_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strt,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             not_valid,
    output logic             idle,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [WIDTH-1:0]   dq_reg, dq_next;
    logic [WIDTH-1:0]   dvs_reg, dvs_next;
    logic               neg_q_reg, neg_q_next;
    logic               neg_r_reg, neg_r_next;
    logic               nv_reg, nv_next;
    logic [WIDTH-1:0]   quotient_reg, quotient_next;
    logic [WIDTH-1:0]   remainder_reg, remainder_next;
    logic               not_valid_reg, not_valid_next;
    logic               idle_reg, idle_next;
    logic               done_reg, done_next;

    logic               sm;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     trial;

`ifdef DIV_SIGNED_EN
    assign sm = signed_mode;
`else
    assign sm = 1'b0;
`endif

    assign dvd_mag = (sm && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    assign dvs_mag = (sm && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;

    // dq_reg doubles as the dividend shifter and the quotient accumulator
    assign trial = {acc_reg, dq_reg[WIDTH-1]} - {1'b0, dvs_reg};

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        dq_next        = dq_reg;
        dvs_next       = dvs_reg;
        neg_q_next     = neg_q_reg;
        neg_r_next     = neg_r_reg;
        nv_next        = nv_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        not_valid_next = not_valid_reg;
        idle_next      = idle_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (strt) begin
                    idle_next  = 1'b0;
                    nv_next    = 1'b0;
                    dvs_next   = dvs_mag;
                    neg_q_next = sm & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_next = sm & dividend[WIDTH-1];
                    if (divisor == '0) begin
                        // Preset result; FIN waits one extra cycle using the counter
                        dq_next    = '1;
                        acc_next   = dividend;
                        nv_next    = 1'b1;
                        neg_q_next = 1'b0;
                        neg_r_next = 1'b0;
                        cnt_next   = CNT_W'(1);
                        state_next = FIN;
                    end else begin
                        dq_next    = dvd_mag;
                        acc_next   = '0;
                        cnt_next   = CNT_W'(WIDTH);
                        state_next = CALC;
`ifdef DIV_SIGNED_EN
                        if (sm && dividend == {1'b1, {(WIDTH-1){1'b0}}} && divisor == '1)
                            nv_next = 1'b1;
`endif
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    acc_next = trial[WIDTH-1:0];
                    dq_next  = {dq_reg[WIDTH-2:0], 1'b1};
                end else begin
                    acc_next = {acc_reg[WIDTH-2:0], dq_reg[WIDTH-1]};
                    dq_next  = {dq_reg[WIDTH-2:0], 1'b0};
                end
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1))
                    state_next = FIN;
            end
            FIN: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    quotient_next  = neg_q_reg ? (~dq_reg + 1'b1) : dq_reg;
                    remainder_next = neg_r_reg ? (~acc_reg + 1'b1) : acc_reg;
                    not_valid_next = nv_reg;
                    done_next      = 1'b1;
                    idle_next      = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                idle_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            dq_reg        <= '0;
            dvs_reg       <= '0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            nv_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            not_valid_reg <= 1'b0;
            idle_reg      <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            dq_reg        <= dq_next;
            dvs_reg       <= dvs_next;
            neg_q_reg     <= neg_q_next;
            neg_r_reg     <= neg_r_next;
            nv_reg        <= nv_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            not_valid_reg <= not_valid_next;
            idle_reg      <= idle_next;
            done_reg      <= done_next;
        end
    end

    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign not_valid = not_valid_reg;
    assign idle      = idle_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_divider_nbit.sv
// Randomised and directed checks of divider_nbit (WIDTH=8 and WIDTH=16 instances)
// against a plain-arithmetic reference model.
module tb_divider_nbit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sm = 1'b0;

    logic        strt8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        nv8, idle8, done8;

    logic        strt16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, q16, r16;
    logic        nv16, idle16, done16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    divider_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .strt(strt8),
        .dividend(a8), .divisor(b8),
`ifdef DIV_SIGNED_EN
        .signed_mode(sm),
`endif
        .quotient(q8), .remainder(r8), .not_valid(nv8),
        .idle(idle8), .done(done8)
    );

    divider_nbit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .strt(strt16),
        .dividend(a16), .divisor(b16),
`ifdef DIV_SIGNED_EN
        .signed_mode(sm),
`endif
        .quotient(q16), .remainder(r16), .not_valid(nv16),
        .idle(idle16), .done(done16)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, truncation toward zero when signed
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic nv);
        longint mask, sa, sb;
        mask = (longint'(1) << w) - 1;
        if (b == 0) begin
            q = 32'(mask); r = a; nv = 1'b1;
        end else if (s) begin
            sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            if (sa == -(longint'(1) << (w-1)) && sb == -1) begin
                q = 32'(longint'(1) << (w-1)); r = 0; nv = 1'b1;
            end else begin
                q = 32'((sa / sb) & mask); r = 32'((sa % sb) & mask); nv = 1'b0;
            end
        end else begin
            q = a / b; r = a % b; nv = 1'b0;
        end
    endtask

    task automatic set_ops(int w, logic [31:0] a, logic [31:0] b);
        if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; end
        else begin a16 = a[15:0]; b16 = b[15:0]; end
    endtask

    task automatic set_strt(int w, logic st);
        if (w == 8) strt8 = st; else strt16 = st;
    endtask

    function automatic logic get_done(int w);
        return (w == 8) ? done8 : done16;
    endfunction

    function automatic logic get_idle(int w);
        return (w == 8) ? idle8 : idle16;
    endfunction

    // One division; optional ignored strt pulse (with other operands) at edge pulse_at
    task automatic run_op(int w, logic [31:0] a, logic [31:0] b, logic s, string tag, int pulse_at);
        logic [31:0] eq, er, gq, gr;
        logic env, idle_hi;
        int n;
        model(w, a, b, s, eq, er, env);
        sm = s;
        set_ops(w, a, b);
        set_strt(w, 1'b1);
        @(posedge clk); #1;
        set_strt(w, 1'b0);
        n = 0;
        idle_hi = 1'b0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            set_strt(w, 1'b0);
            if (get_done(w)) break;
            if (get_idle(w)) idle_hi = 1'b1;
            if (n == pulse_at) begin
                set_ops(w, 9, 3);
                set_strt(w, 1'b1);
            end
        end
        gq = (w == 8) ? 32'(q8) : 32'(q16);
        gr = (w == 8) ? 32'(r8) : 32'(r16);
        $display("[TB] %s w=%0d a=%0h b=%0h s=%0b q=%0h r=%0h nv=%0b lat=%0d",
                 tag, w, a, b, s, gq, gr, (w == 8) ? nv8 : nv16, n);
        check({tag, "_lat"}, n, (b == 0) ? 2 : w + 1);
        check({tag, "_q"}, gq, eq);
        check({tag, "_r"}, gr, er);
        check({tag, "_nv"}, (w == 8) ? nv8 : nv16, env);
        check({tag, "_busy"}, idle_hi, 1'b0);
        @(posedge clk); #1;
        check({tag, "_strobe"}, get_done(w), 1'b0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic s;
        int e, prev, cnt;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_q", q8, 0);
        check("rst_r", r8, 0);
        check("rst_nv", nv8, 0);
        check("rst_done", done8, 0);
        check("rst_idle", idle8, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8, 25, 5, 1'b0, "d25_5", 0);
        run_op(8, 200, 7, 1'b0, "d200_7_pulse", 4);
        run_op(8, 37, 0, 1'b0, "d37_0", 0);
        run_op(8, 10, 3, 1'b0, "d10_3", 0);
        run_op(8, 0, 5, 1'b0, "d0_5", 0);
        run_op(8, 3, 200, 1'b0, "d3_200", 0);

        // Reset in the middle of a division
        a8 = 100; b8 = 9; strt8 = 1'b1;
        @(posedge clk); #1;
        strt8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_q", q8, 0);
        check("midrst_r", r8, 0);
        check("midrst_idle", idle8, 1);
        check("midrst_done", done8, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        $display("[TB] midrst done_seen=%0b", seen);
        check("midrst_nodone", seen, 0);
        run_op(8, 100, 9, 1'b0, "d100_9", 0);

        // strt held high: back-to-back divisions every WIDTH+2 cycles
        a8 = 255; b8 = 16; strt8 = 1'b1;
        @(posedge clk); #1;
        e = 0; prev = 0; cnt = 0;
        while (cnt < 3 && e < 60) begin
            @(posedge clk); #1;
            e++;
            if (done8) begin
                $display("[TB] b2b op=%0d edge=%0d q=%0h r=%0h", cnt, e, q8, r8);
                check("b2b_gap", e - prev, (cnt == 0) ? 9 : 10);
                check("b2b_q", q8, 15);
                check("b2b_r", r8, 15);
                prev = e;
                cnt++;
            end
        end
        strt8 = 1'b0;
        check("b2b_count", cnt, 3);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        check("b2b_stop", seen, 0);

        run_op(16, 60000, 7, 1'b0, "w16_60000_7", 0);
        run_op(16, 1234, 0, 1'b0, "w16_div0", 0);

`ifdef DIV_SIGNED_EN
        run_op(8, 8'hE7, 4, 1'b1, "s_m25_4", 0);
        run_op(8, 8'h80, 8'hFF, 1'b1, "s_m128_m1", 0);
        run_op(8, 8'hF0, 0, 1'b1, "s_div0", 0);
        run_op(16, 16'h8000, 16'hFFFF, 1'b1, "s16_ovf", 0);
`endif

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(8, {24'b0, a[7:0]}, {24'b0, b[7:0]}, s, "rnd8", 0);
        end
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom;
`ifdef DIV_SIGNED_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            run_op(16, {16'b0, a[15:0]}, {16'b0, b[15:0]}, s, "rnd16", 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
